// File: rtl/usb_dev_rw_responder_if.sv
// Bus bundle for the USB device read/write responder: protocol-FSM token/data
// events, IN payload handshake, local memory req/gnt port and status pulses.
interface usb_dev_rw_responder_if;
    logic        tok_valid;
    logic        tok_in;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic        rx_valid;
    logic        rx_err;
    logic [63:0] rx_data;
    logic        resp_valid;
    logic        resp_nak;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic        tx_ready;
    logic        host_ack;
    logic        host_err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic [63:0] mem_rdata;
    logic        xfer_done;
    logic        xfer_abort;

    modport slave (
        input  tok_valid, tok_in, tok_addr, tok_endp,
        input  rx_valid, rx_err, rx_data,
        input  tx_ready, host_ack, host_err,
        input  mem_gnt, mem_rdata,
        output resp_valid, resp_nak, tx_valid, tx_data,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output xfer_done, xfer_abort
    );

    modport master (
        output tok_valid, tok_in, tok_addr, tok_endp,
        output rx_valid, rx_err, rx_data,
        output tx_ready, host_ack, host_err,
        output mem_gnt, mem_rdata,
        input  resp_valid, resp_nak, tx_valid, tx_data,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  xfer_done, xfer_abort
    );
endinterface

// File: rtl/usb_dev_rw_responder.sv
// Device-side responder: latches a 16-bit address from an OUT on ADDR_ENDP, then
// services OUT (write) / IN (read) on DATA_ENDP against a 64-bit local memory.
module usb_dev_rw_responder #(
    parameter logic [6:0] DEV_ADDR  = 7'd5,
    parameter logic [3:0] ADDR_ENDP = 4'd4,
    parameter logic [3:0] DATA_ENDP = 4'd8,
    parameter int         TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst_L,
    usb_dev_rw_responder_if.slave bus
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_RX = 3'd1,
        ARMED   = 3'd2,
        WR_RX   = 3'd3,
        WR_MEM  = 3'd4,
        RD_MEM  = 3'd5,
        RD_TX   = 3'd6,
        RD_ACK  = 3'd7
    } state_t;

    state_t      state_r;
    logic [15:0] addr_q_r;
    logic [63:0] data_q_r;
    logic [7:0]  timer_r;
    logic        rd_hold_r;
    logic        resp_valid_r, resp_nak_r, tx_valid_r, mem_req_r, mem_we_r;
    logic        xfer_done_r, xfer_abort_r;

    logic        rx_evt_s, tok_acc_s, addr_out_s, data_out_s, data_in_s;
    logic        progress_s, timeout_s;

    // Token qualification and the "something happened" term that holds off the timer
    always_comb begin
        rx_evt_s   = bus.rx_valid | bus.rx_err;
        tok_acc_s  = bus.tok_valid && (bus.tok_addr == DEV_ADDR) &&
                     ((bus.tok_endp == ADDR_ENDP) || (bus.tok_endp == DATA_ENDP)) &&
                     !rx_evt_s;
        addr_out_s = tok_acc_s && !bus.tok_in && (bus.tok_endp == ADDR_ENDP);
        data_out_s = tok_acc_s && !bus.tok_in && (bus.tok_endp == DATA_ENDP);
        data_in_s  = tok_acc_s &&  bus.tok_in && (bus.tok_endp == DATA_ENDP);
        progress_s = tok_acc_s;
        case (state_r)
            ADDR_RX, WR_RX: progress_s = tok_acc_s | rx_evt_s;
            WR_MEM, RD_MEM: progress_s = tok_acc_s | bus.mem_gnt;
            RD_TX:          progress_s = tok_acc_s | bus.tx_ready;
            RD_ACK:         progress_s = tok_acc_s | bus.host_ack | bus.host_err;
            default:        progress_s = tok_acc_s;
        endcase
        timeout_s = (state_r != IDLE) && !progress_s && (timer_r == TMO_LAST);
    end

    // Transaction FSM with registered handshake outputs and idle timer
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_r      <= IDLE;
            addr_q_r     <= 16'd0;
            data_q_r     <= 64'd0;
            timer_r      <= 8'd0;
            rd_hold_r    <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_nak_r   <= 1'b0;
            tx_valid_r   <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            xfer_done_r  <= 1'b0;
            xfer_abort_r <= 1'b0;
        end else begin
            resp_valid_r <= 1'b0;
            resp_nak_r   <= 1'b0;
            xfer_done_r  <= 1'b0;
            xfer_abort_r <= 1'b0;
            if (timeout_s) begin
                state_r      <= IDLE;
                timer_r      <= 8'd0;
                rd_hold_r    <= 1'b0;
                tx_valid_r   <= 1'b0;
                mem_req_r    <= 1'b0;
                mem_we_r     <= 1'b0;
                xfer_abort_r <= 1'b1;
            end else begin
                timer_r <= (progress_s || (state_r == IDLE)) ? 8'd0 : timer_r + 8'd1;
                case (state_r)
                    IDLE: begin
                        if (addr_out_s) begin
                            state_r   <= ADDR_RX;
                            rd_hold_r <= 1'b0;
                        end else if (data_out_s || data_in_s) begin
                            resp_valid_r <= 1'b1;
                            resp_nak_r   <= 1'b1;
                        end
                    end
                    ADDR_RX: begin
                        // rx_err leaves us here silently so the host can resend the OUT
                        if (bus.rx_valid) begin
                            addr_q_r     <= bus.rx_data[15:0];
                            resp_valid_r <= 1'b1;
                            state_r      <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (addr_out_s) begin
                            state_r   <= ADDR_RX;
                            rd_hold_r <= 1'b0;
                        end else if (data_out_s) begin
                            state_r <= WR_RX;
                        end else if (data_in_s && rd_hold_r) begin
                            state_r    <= RD_TX;
                            tx_valid_r <= 1'b1;
                        end else if (data_in_s) begin
                            state_r   <= RD_MEM;
                            mem_req_r <= 1'b1;
                            mem_we_r  <= 1'b0;
                        end
                    end
                    WR_RX: begin
                        if (bus.rx_valid) begin
                            data_q_r  <= bus.rx_data;
                            state_r   <= WR_MEM;
                            mem_req_r <= 1'b1;
                            mem_we_r  <= 1'b1;
                        end else if (bus.rx_err) begin
                            state_r <= ARMED;
                        end
                    end
                    WR_MEM: begin
                        if (bus.mem_gnt) begin
                            mem_req_r    <= 1'b0;
                            mem_we_r     <= 1'b0;
                            resp_valid_r <= 1'b1;
                            xfer_done_r  <= 1'b1;
                            rd_hold_r    <= 1'b0;
                            state_r      <= IDLE;
                        end
                    end
                    RD_MEM: begin
                        if (bus.mem_gnt) begin
                            data_q_r   <= bus.mem_rdata;
                            mem_req_r  <= 1'b0;
                            tx_valid_r <= 1'b1;
                            state_r    <= RD_TX;
                        end
                    end
                    RD_TX: begin
                        if (bus.tx_ready) begin
                            tx_valid_r <= 1'b0;
                            state_r    <= RD_ACK;
                        end
                    end
                    RD_ACK: begin
                        // A lost host handshake keeps data_q so the retry skips memory
                        if (bus.host_ack) begin
                            xfer_done_r <= 1'b1;
                            rd_hold_r   <= 1'b0;
                            state_r     <= IDLE;
                        end else if (bus.host_err) begin
                            rd_hold_r <= 1'b1;
                            state_r   <= ARMED;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        mem_req_r  <= 1'b0;
                        tx_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_nak   = resp_nak_r;
    assign bus.tx_valid   = tx_valid_r;
    assign bus.tx_data    = data_q_r;
    assign bus.mem_req    = mem_req_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = addr_q_r;
    assign bus.mem_wdata  = data_q_r;
    assign bus.xfer_done  = xfer_done_r;
    assign bus.xfer_abort = xfer_abort_r;
endmodule

// File: tb/tb_usb_dev_rw_responder.sv
// Directed bench for usb_dev_rw_responder: write, read, read retry, address
// error retry, foreign/early tokens, idle timeout and mid-transfer reset.
module tb_usb_dev_rw_responder;
    logic clk = 1'b0;
    logic rst_L = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   gnt_cnt = 0;
    int   ack_cnt = 0;
    int   done_cnt = 0;
    logic [15:0] wr_addr = 16'd0;
    logic [63:0] wr_data = 64'd0;

    usb_dev_rw_responder_if bus();

    usb_dev_rw_responder dut (
        .clk   (clk),
        .rst_L (rst_L),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observe grants, ACKs and completions as seen on each rising edge
    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_gnt) begin
            gnt_cnt <= gnt_cnt + 1;
            if (bus.mem_we) begin
                wr_addr <= bus.mem_addr;
                wr_data <= bus.mem_wdata;
            end
        end
        if (bus.resp_valid && !bus.resp_nak) ack_cnt <= ack_cnt + 1;
        if (bus.xfer_done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_tok(input logic in, input logic [6:0] a, input logic [3:0] e);
        bus.tok_valid = 1'b1;
        bus.tok_in    = in;
        bus.tok_addr  = a;
        bus.tok_endp  = e;
        tick();
        bus.tok_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [63:0] d);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_tx_ready();
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
    endtask

    task automatic grant(input logic [63:0] rd);
        bus.mem_gnt   = 1'b1;
        bus.mem_rdata = rd;
        tick();
        bus.mem_gnt   = 1'b0;
        bus.mem_rdata = 64'd0;
    endtask

    initial begin
        int ack0, done0, gnt0, n;
        bus.tok_valid = 1'b0; bus.tok_in = 1'b0; bus.tok_addr = 7'd0; bus.tok_endp = 4'd0;
        bus.rx_valid = 1'b0; bus.rx_err = 1'b0; bus.rx_data = 64'd0;
        bus.tx_ready = 1'b0; bus.host_ack = 1'b0; bus.host_err = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rdata = 64'd0;

        // Reset state
        tick(); tick();
        chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("rst_tx_valid",   {63'd0, bus.tx_valid},   64'd0);
        chk("rst_mem_req",    {63'd0, bus.mem_req},    64'd0);
        chk("rst_mem_addr",   {48'd0, bus.mem_addr},   64'd0);
        chk("rst_tx_data",    bus.tx_data,             64'd0);
        rst_L = 1'b1;
        tick();

        // Write: address 0x1234, data DEADBEEFCAFEF00D, grant after 3 cycles
        ack0 = ack_cnt; done0 = done_cnt;
        send_tok(1'b0, 7'd5, 4'd4);
        chk("wr_no_resp_on_tok", {63'd0, bus.resp_valid}, 64'd0);
        send_rx(64'hFFFF_0000_0000_1234);
        chk("wr_addr_ack", {62'd0, bus.resp_valid, bus.resp_nak}, 64'd2);
        tick();
        chk("wr_addr_ack_1cyc", {63'd0, bus.resp_valid}, 64'd0);
        send_tok(1'b0, 7'd5, 4'd8);
        send_rx(64'hDEAD_BEEF_CAFE_F00D);
        chk("wr_no_early_ack", {63'd0, bus.resp_valid}, 64'd0);
        chk("wr_req_we", {62'd0, bus.mem_req, bus.mem_we}, 64'd3);
        tick(); tick(); tick();
        chk("wr_req_held", {63'd0, bus.mem_req}, 64'd1);
        grant(64'd0);
        chk("wr_ack_done", {61'd0, bus.resp_valid, bus.resp_nak, bus.xfer_done}, 64'd5);
        chk("wr_req_drop", {63'd0, bus.mem_req}, 64'd0);
        chk("wr_mem_addr", {48'd0, wr_addr}, 64'h1234);
        chk("wr_mem_data", wr_data, 64'hDEAD_BEEF_CAFE_F00D);
        tick();
        chk("wr_ack_count", 64'(ack_cnt - ack0), 64'd2);
        chk("wr_done_count", 64'(done_cnt - done0), 64'd1);

        // Read: address 0x0040, memory returns 0123456789ABCDEF
        done0 = done_cnt;
        send_tok(1'b0, 7'd5, 4'd4);
        send_rx(64'h0000_0000_0000_0040);
        send_tok(1'b1, 7'd5, 4'd8);
        chk("rd_req", {62'd0, bus.mem_req, bus.mem_we}, 64'd2);
        chk("rd_addr", {48'd0, bus.mem_addr}, 64'h0040);
        grant(64'h0123_4567_89AB_CDEF);
        chk("rd_tx_valid", {62'd0, bus.tx_valid, bus.mem_req}, 64'd2);
        chk("rd_tx_data", bus.tx_data, 64'h0123_4567_89AB_CDEF);
        tick();
        chk("rd_tx_held", {63'd0, bus.tx_valid}, 64'd1);
        pulse_tx_ready();
        chk("rd_tx_drop", {63'd0, bus.tx_valid}, 64'd0);
        bus.host_ack = 1'b1; tick(); bus.host_ack = 1'b0;
        chk("rd_done", {63'd0, bus.xfer_done}, 64'd1);
        tick();
        chk("rd_done_count", 64'(done_cnt - done0), 64'd1);

        // Read with host_err, retry served from held data with no second memory read
        gnt0 = gnt_cnt; done0 = done_cnt;
        send_tok(1'b0, 7'd5, 4'd4);
        send_rx(64'h0000_0000_0000_0080);
        send_tok(1'b1, 7'd5, 4'd8);
        grant(64'hA5A5_5A5A_0F0F_F0F0);
        pulse_tx_ready();
        bus.host_err = 1'b1; tick(); bus.host_err = 1'b0;
        chk("retry_no_done", {62'd0, bus.xfer_done, bus.tx_valid}, 64'd0);
        send_tok(1'b1, 7'd5, 4'd8);
        chk("retry_tx_direct", {62'd0, bus.tx_valid, bus.mem_req}, 64'd2);
        chk("retry_tx_data", bus.tx_data, 64'hA5A5_5A5A_0F0F_F0F0);
        pulse_tx_ready();
        bus.host_ack = 1'b1; tick(); bus.host_ack = 1'b0;
        chk("retry_done", {63'd0, bus.xfer_done}, 64'd1);
        tick();
        chk("retry_one_gnt", 64'(gnt_cnt - gnt0), 64'd1);
        chk("retry_done_count", 64'(done_cnt - done0), 64'd1);

        // Foreign device address and IN on data endpoint while idle
        gnt0 = gnt_cnt;
        send_tok(1'b0, 7'd3, 4'd4);
        chk("foreign_tok_ignored", {63'd0, bus.resp_valid}, 64'd0);
        send_rx(64'h0000_0000_0000_7777);
        chk("foreign_no_addr_ack", {63'd0, bus.resp_valid}, 64'd0);
        send_tok(1'b1, 7'd5, 4'd8);
        chk("idle_in_nak", {62'd0, bus.resp_valid, bus.resp_nak}, 64'd3);
        tick();
        chk("idle_no_mem", {63'd0, bus.mem_req}, 64'd0);
        chk("idle_no_gnt", 64'(gnt_cnt - gnt0), 64'd0);

        // Address payload error then good retry, then idle timeout from ARMED
        send_tok(1'b0, 7'd5, 4'd4);
        bus.rx_err = 1'b1; tick(); bus.rx_err = 1'b0;
        chk("addr_err_no_resp", {63'd0, bus.resp_valid}, 64'd0);
        tick();
        chk("addr_err_no_resp2", {63'd0, bus.resp_valid}, 64'd0);
        send_rx(64'h1111_2222_3333_ABCD);
        chk("addr_retry_ack", {62'd0, bus.resp_valid, bus.resp_nak}, 64'd2);
        chk("addr_latched", {48'd0, bus.mem_addr}, 64'hABCD);
        n = 0;
        while (!bus.xfer_abort && n < 400) begin
            tick();
            n++;
        end
        chk("abort_cycles", 64'(n), 64'd255);
        chk("abort_pulse", {63'd0, bus.xfer_abort}, 64'd1);
        tick();
        chk("abort_1cyc", {63'd0, bus.xfer_abort}, 64'd0);
        send_tok(1'b1, 7'd5, 4'd8);
        chk("abort_back_idle", {62'd0, bus.resp_valid, bus.resp_nak}, 64'd3);

        // Reset asserted while an IN payload is being offered
        send_tok(1'b0, 7'd5, 4'd4);
        send_rx(64'h0000_0000_0000_0010);
        send_tok(1'b1, 7'd5, 4'd8);
        grant(64'hFFFF_FFFF_FFFF_FFFF);
        chk("pre_rst_tx_valid", {63'd0, bus.tx_valid}, 64'd1);
        rst_L = 1'b0;
        #1;
        chk("rst_mid_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
        chk("rst_mid_tx_data",  bus.tx_data, 64'd0);
        chk("rst_mid_mem_addr", {48'd0, bus.mem_addr}, 64'd0);
        tick();
        rst_L = 1'b1;
        tick();
        send_tok(1'b1, 7'd5, 4'd8);
        chk("rst_mid_idle_nak", {62'd0, bus.resp_valid, bus.resp_nak}, 64'd3);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
